// File: rtl/ps_one.sv
// PlayStation 1 digital pad poller: clocks a 5-byte poll frame over the pad bus and forwards the button word on a UART line.
// Latency: first frame starts 4 cycles after a start key press, then one frame every CLK_HZ/POLL_HZ cycles; UART begins 1 cycle after a valid frame ends.
// No backpressure: a frame waits for the pad ACK (with timeout), and a frame's UART send is dropped, never queued, if the transmitter is still busy.
module ps_one #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int SPI_HZ  = 250_000,
    parameter int BAUD    = 115_200,
    parameter int POLL_HZ = 60,
    parameter int ACK_TO  = 5_000
) (
    input  logic iCLK,
    input  logic iRESET,
    input  logic iKEY_ST,
    output logic oCS,
    output logic oCLK,
    output logic oMOSI,
    input  logic iMISO,
    input  logic iACK,
    input  logic iRX,
    output logic oTX
);

    localparam logic [31:0] H_CYC  = 32'(CLK_HZ / (2 * SPI_HZ));
    localparam logic [31:0] B_CYC  = 32'(CLK_HZ / BAUD);
    localparam logic [31:0] P_CYC  = 32'(CLK_HZ / POLL_HZ);
    localparam logic [31:0] TO_CYC = 32'(ACK_TO);

    typedef enum logic [2:0] {F_IDLE, F_SETUP, F_BYTE, F_ACKWAIT, F_GAP, F_END} fstate_t;
    typedef enum logic {T_IDLE, T_BUSY} tstate_t;

    // The UART receive line is reserved; it is deliberately left unconnected.
    logic rx_unused;
    assign rx_unused = iRX;

    // Input synchronizers; the key chain has a third stage for edge detection.
    logic [2:0] key_sy;
    logic [1:0] miso_sy;
    logic [1:0] ack_sy;
    logic       key_rise;
    logic       miso_s;
    logic       ack_s;

    // Two-flop synchronizers for the asynchronous key and pad inputs.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            key_sy  <= 3'b000;
            miso_sy <= 2'b11;
            ack_sy  <= 2'b11;
        end else begin
            key_sy  <= {key_sy[1:0], iKEY_ST};
            miso_sy <= {miso_sy[0], iMISO};
            ack_sy  <= {ack_sy[0], iACK};
        end
    end

    assign key_rise = key_sy[1] & ~key_sy[2];
    assign miso_s   = miso_sy[1];
    assign ack_s    = ack_sy[1];

    // Run state and poll timer.
    logic        run;
    logic        due;
    logic [31:0] poll_cnt;
    logic        frame_start;

    fstate_t     fst;
    logic [31:0] fcnt;
    logic [2:0]  bit_idx;
    logic [2:0]  byte_idx;
    logic [7:0]  rx_sh;
    logic [7:0]  r1;
    logic [7:0]  r2;
    logic [7:0]  r3;
    logic [15:0] buttons;
    logic        tx_go;
    logic        tx_idle;
    logic [7:0]  cmd_cur;

    assign frame_start = (fst == F_IDLE) && run && due;

    // Key toggles run; starting arms an immediate frame, then the timer re-arms every poll period.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            run      <= 1'b0;
            due      <= 1'b0;
            poll_cnt <= 32'd0;
        end else if (key_rise) begin
            run      <= ~run;
            due      <= ~run;
            poll_cnt <= 32'd0;
        end else if (run) begin
            if (frame_start) begin
                due <= 1'b0;
            end
            if (poll_cnt == P_CYC - 32'd1) begin
                poll_cnt <= 32'd0;
                due      <= 1'b1;
            end else begin
                poll_cnt <= poll_cnt + 32'd1;
            end
        end
    end

    // Command byte for the byte currently being shifted out.
    always_comb begin
        cmd_cur = 8'h00;
        case (byte_idx)
            3'd0:    cmd_cur = 8'h01;
            3'd1:    cmd_cur = 8'h42;
            default: cmd_cur = 8'h00;
        endcase
    end

    // Frame sequencer: drives CS/CLK/MOSI, shifts in MISO, validates the reply.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            fst      <= F_IDLE;
            oCS      <= 1'b1;
            oCLK     <= 1'b1;
            oMOSI    <= 1'b1;
            fcnt     <= 32'd0;
            bit_idx  <= 3'd0;
            byte_idx <= 3'd0;
            rx_sh    <= 8'h00;
            r1       <= 8'h00;
            r2       <= 8'h00;
            r3       <= 8'h00;
            buttons  <= 16'hFFFF;
            tx_go    <= 1'b0;
        end else begin
            tx_go <= 1'b0;
            case (fst)
                F_IDLE: begin
                    if (frame_start) begin
                        fst      <= F_SETUP;
                        oCS      <= 1'b0;
                        fcnt     <= 32'd0;
                        byte_idx <= 3'd0;
                        bit_idx  <= 3'd0;
                    end
                end
                F_SETUP, F_GAP: begin
                    if (fcnt == H_CYC - 32'd1) begin
                        fst     <= F_BYTE;
                        fcnt    <= 32'd0;
                        bit_idx <= 3'd0;
                        oCLK    <= 1'b0;
                        oMOSI   <= cmd_cur[0];
                    end else begin
                        fcnt <= fcnt + 32'd1;
                    end
                end
                F_BYTE: begin
                    if (fcnt != H_CYC - 32'd1) begin
                        fcnt <= fcnt + 32'd1;
                    end else begin
                        fcnt <= 32'd0;
                        if (!oCLK) begin
                            // Rising pad clock: capture the pad's bit, LSB first.
                            oCLK  <= 1'b1;
                            rx_sh <= {miso_s, rx_sh[7:1]};
                        end else if (bit_idx != 3'd7) begin
                            bit_idx <= bit_idx + 3'd1;
                            oCLK    <= 1'b0;
                            oMOSI   <= cmd_cur[bit_idx + 3'd1];
                        end else begin
                            oMOSI <= 1'b1;
                            case (byte_idx)
                                3'd1:    r1 <= rx_sh;
                                3'd2:    r2 <= rx_sh;
                                3'd3:    r3 <= rx_sh;
                                default: ;
                            endcase
                            if (byte_idx == 3'd4) begin
                                fst <= F_END;
                            end else begin
                                byte_idx <= byte_idx + 3'd1;
                                fst      <= F_ACKWAIT;
                            end
                        end
                    end
                end
                F_ACKWAIT: begin
                    if (!ack_s) begin
                        fst  <= F_GAP;
                        fcnt <= 32'd0;
                    end else if (fcnt == TO_CYC - 32'd1) begin
                        // Pad went silent: drop the frame without touching the UART.
                        fst  <= F_IDLE;
                        oCS  <= 1'b1;
                        fcnt <= 32'd0;
                    end else begin
                        fcnt <= fcnt + 32'd1;
                    end
                end
                F_END: begin
                    if (fcnt == H_CYC - 32'd1) begin
                        fst  <= F_IDLE;
                        oCS  <= 1'b1;
                        fcnt <= 32'd0;
                        // rx_sh still holds the last byte (r4).
                        if (r1 == 8'h41 && r2 == 8'h5A) begin
                            buttons <= {rx_sh, r3};
                            tx_go   <= tx_idle;
                        end
                    end else begin
                        fcnt <= fcnt + 32'd1;
                    end
                end
                default: fst <= F_IDLE;
            endcase
        end
    end

    // UART transmitter state.
    tstate_t     tst;
    logic [31:0] tcnt;
    logic [3:0]  tbit;
    logic [1:0]  tbyte;
    logic [9:0]  tsh;
    logic [15:0] tdat;

    assign tx_idle = (tst == T_IDLE);

    // 8N1 sender for the 3-byte report 0xA5, buttons[7:0], buttons[15:8].
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            tst   <= T_IDLE;
            oTX   <= 1'b1;
            tcnt  <= 32'd0;
            tbit  <= 4'd0;
            tbyte <= 2'd0;
            tsh   <= 10'h3FF;
            tdat  <= 16'hFFFF;
        end else begin
            case (tst)
                T_IDLE: begin
                    if (tx_go) begin
                        tst   <= T_BUSY;
                        tsh   <= {1'b1, 8'hA5, 1'b0};
                        tdat  <= buttons;
                        oTX   <= 1'b0;
                        tcnt  <= 32'd0;
                        tbit  <= 4'd0;
                        tbyte <= 2'd0;
                    end
                end
                T_BUSY: begin
                    if (tcnt != B_CYC - 32'd1) begin
                        tcnt <= tcnt + 32'd1;
                    end else begin
                        tcnt <= 32'd0;
                        if (tbit == 4'd9) begin
                            if (tbyte == 2'd2) begin
                                tst <= T_IDLE;
                                oTX <= 1'b1;
                            end else begin
                                tbyte <= tbyte + 2'd1;
                                tbit  <= 4'd0;
                                oTX   <= 1'b0;
                                tsh   <= {1'b1, (tbyte == 2'd0) ? tdat[7:0] : tdat[15:8], 1'b0};
                            end
                        end else begin
                            tbit <= tbit + 4'd1;
                            tsh  <= {1'b1, tsh[9:1]};
                            oTX  <= tsh[1];
                        end
                    end
                end
                default: tst <= T_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps_one.sv
module tb_ps_one;

    localparam int CLK_HZ  = 3000;
    localparam int SPI_HZ  = 300;
    localparam int BAUD    = 375;
    localparam int POLL_HZ = 2;
    localparam int ACK_TO  = 100;
    localparam int H  = CLK_HZ / (2 * SPI_HZ);
    localparam int B  = CLK_HZ / BAUD;
    localparam int P  = CLK_HZ / POLL_HZ;
    localparam int NF = 12;

    logic iCLK, iRESET, iKEY_ST, iMISO, iACK, iRX;
    logic oCS, oCLK, oMOSI, oTX;

    ps_one #(
        .CLK_HZ(CLK_HZ), .SPI_HZ(SPI_HZ), .BAUD(BAUD), .POLL_HZ(POLL_HZ), .ACK_TO(ACK_TO)
    ) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iKEY_ST(iKEY_ST),
        .oCS(oCS), .oCLK(oCLK), .oMOSI(oMOSI),
        .iMISO(iMISO), .iACK(iACK), .iRX(iRX), .oTX(oTX)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int fails_shown = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (fails_shown < 40) $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
            fails_shown++;
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            if (fails_shown < 40) $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
            fails_shown++;
        end
    endtask

    function automatic logic [7:0] exp_cmd(input int k);
        case (k)
            0:       return 8'h01;
            1:       return 8'h42;
            default: return 8'h00;
        endcase
    endfunction

    // Per-frame pad behaviour.
    logic [7:0] cfg_r   [NF][5];
    logic       cfg_ack [NF][4];
    int         cfg_d   [NF];

    // Model / monitor state shared between processes.
    bit         run_model = 0;
    bit         fresh_press = 0;
    bit         rst_abort = 0;
    int         key_cyc = 0;
    int         last_start = 0;
    int         fidx = -1;
    int         starts = 0;
    int         nbit = 0;
    int         nbyte = 0;
    int         uart_free = 0;
    int         u_on = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_log[$];
    logic [7:0] f0cmd [5];

    // Pad model, bus monitor, UART receiver and comparison against the model.
    initial begin
        bit pcs, pclk, ptx;
        int fi, fall_cyc, rise_cyc, ack_cnt, ack_w, ut, low_len, ab;
        bit low_done, valid;
        logic [7:0] sh, ub;
        logic [7:0] cmd_seen [5];
        pcs = 1; pclk = 1; ptx = 1;
        fi = 0; fall_cyc = 0; rise_cyc = 0; ack_cnt = 0; ack_w = 0;
        ut = 0; low_len = 0; low_done = 0; sh = 8'h00; ub = 8'h00;
        forever begin
            @(negedge iCLK);
            if (oCS) begin
                chk("idle_clk", oCLK, 1);
                chk("idle_mosi", oMOSI, 1);
            end
            if (pcs && !oCS) begin
                fidx++;
                starts++;
                fi = (fidx < NF) ? fidx : NF - 1;
                chk("start_allowed", run_model, 1);
                if (fresh_press) chk_rng("start_latency", cyc - key_cyc, 1, 4);
                else chk("poll_period", cyc - last_start, P);
                fresh_press = 0;
                last_start = cyc;
                nbit = 0;
                nbyte = 0;
            end
            if (!oCS) begin
                if (pclk && !oCLK) begin
                    if (nbit != 0) chk("clk_high_len", cyc - rise_cyc, H);
                    if (nbyte < 5) iMISO = cfg_r[fi][nbyte][nbit];
                    fall_cyc = cyc;
                end
                if (!pclk && oCLK) begin
                    chk("clk_low_len", cyc - fall_cyc, H);
                    sh[nbit] = oMOSI;
                    nbit++;
                    rise_cyc = cyc;
                    if (nbit == 8) begin
                        if (nbyte < 5) cmd_seen[nbyte] = sh;
                        nbyte++;
                        nbit = 0;
                        iMISO = 1'b1;
                        if (nbyte <= 4 && cfg_ack[fi][nbyte-1]) ack_cnt = cfg_d[fi];
                    end
                end
            end
            if (!pcs && oCS && !rst_abort) begin
                ab = -1;
                for (int k = 0; k < 4; k++) if (!cfg_ack[fi][k] && ab < 0) ab = k;
                if (ab >= 0) begin
                    chk("abort_bytes", nbyte, ab + 1);
                    chk("abort_time", cyc - rise_cyc, H + ACK_TO);
                end else begin
                    chk("frame_bytes", nbyte, 5);
                    valid = (cfg_r[fi][1] == 8'h41) && (cfg_r[fi][2] == 8'h5A);
                    if (valid && cyc >= uart_free) begin
                        exp_q.push_back(8'hA5);
                        exp_q.push_back(cfg_r[fi][3]);
                        exp_q.push_back(cfg_r[fi][4]);
                        uart_free = cyc + 30 * B + 4;
                    end
                end
                for (int k = 0; k < 5; k++) begin
                    if (k < nbyte) chk("cmd_byte", cmd_seen[k], exp_cmd(k));
                    if (fidx == 0) f0cmd[k] = cmd_seen[k];
                end
            end
            if (ack_w > 0) begin
                ack_w--;
                if (ack_w == 0) iACK = 1'b1;
            end
            if (ack_cnt > 0) begin
                ack_cnt--;
                if (ack_cnt == 0) begin
                    iACK = 1'b0;
                    ack_w = 2;
                end
            end
            if (u_on == 0) begin
                if (ptx && !oTX) begin
                    u_on = 1; ut = 0; low_done = 0; low_len = 0;
                end
            end else begin
                ut++;
                if (!low_done && oTX) begin
                    low_len = ut;
                    low_done = 1;
                end
                for (int k = 0; k < 8; k++) if (ut == B + B / 2 + k * B) ub[k] = oTX;
                if (ut == 9 * B + B / 2) begin
                    chk("uart_stop", oTX, 1);
                    if (ub[0]) chk("uart_bit_len", low_len, B);
                    rx_log.push_back(ub);
                    chk("uart_expected_pending", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) chk("uart_byte", ub, exp_q.pop_front());
                    u_on = 0;
                end
            end
            pcs = oCS; pclk = oCLK; ptx = oTX;
        end
    end

    task automatic press();
        @(negedge iCLK);
        iKEY_ST = 1'b1;
        key_cyc = cyc;
        @(negedge iCLK);
        iKEY_ST = 1'b0;
    endtask

    initial begin
        iRESET = 1'b0; iKEY_ST = 1'b0; iMISO = 1'b1; iACK = 1'b1; iRX = 1'b1;
        for (int f = 0; f < NF; f++) begin
            cfg_r[f][0] = 8'($urandom);
            cfg_r[f][1] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h41;
            cfg_r[f][2] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h5A;
            cfg_r[f][3] = 8'($urandom);
            cfg_r[f][4] = 8'($urandom);
            for (int k = 0; k < 4; k++) cfg_ack[f][k] = ($urandom_range(0, 7) != 0);
            cfg_d[f] = $urandom_range(8, 40);
        end
        cfg_r[0][0] = 8'hFF; cfg_r[0][1] = 8'h41; cfg_r[0][2] = 8'h5A;
        cfg_r[0][3] = 8'hFE; cfg_r[0][4] = 8'hFF; cfg_d[0] = 10;
        for (int k = 0; k < 4; k++) begin
            cfg_ack[0][k] = 1'b1;
            cfg_ack[1][k] = 1'b0;
            cfg_ack[2][k] = 1'b1;
            cfg_ack[NF-1][k] = 1'b1;
        end
        cfg_r[2][1] = 8'h73; cfg_r[2][2] = 8'h5A;
        cfg_r[NF-1][1] = 8'h41; cfg_r[NF-1][2] = 8'h5A;

        @(negedge iCLK);
        iRESET = 1'b1;
        repeat (10) begin
            @(negedge iCLK);
            chk("rst_cs", oCS, 1);
            chk("rst_clk", oCLK, 1);
            chk("rst_mosi", oMOSI, 1);
            chk("rst_tx", oTX, 1);
        end

        run_model = 1; fresh_press = 1;
        press();
        for (int t = 0; t < 3000 && rx_log.size() < 3; t++) @(negedge iCLK);
        chk("f0_uart_count", rx_log.size(), 3);
        if (rx_log.size() >= 3) begin
            chk("f0_uart_hdr", rx_log[0], 8'hA5);
            chk("f0_uart_lo", rx_log[1], 8'hFE);
            chk("f0_uart_hi", rx_log[2], 8'hFF);
        end
        chk("f0_cmd0", f0cmd[0], 8'h01);
        chk("f0_cmd1", f0cmd[1], 8'h42);

        for (int t = 0; t < 4 * P && fidx < 3; t++) @(negedge iCLK);
        chk("reach_frame3", fidx, 3);
        chk("no_uart_abort_invalid", rx_log.size(), 3);

        for (int t = 0; t < NF * P && !(fidx == NF - 1 && !oCS && nbyte >= 2); t++) @(negedge iCLK);
        chk("reach_stop_frame", fidx, NF - 1);
        run_model = 0;
        press();
        repeat (2 * P + 400) @(negedge iCLK);
        chk("starts_after_stop", starts, NF);
        chk("uart_drained", exp_q.size(), 0);

        run_model = 1; fresh_press = 1;
        press();
        for (int t = 0; t < 400 && !(fidx == NF && nbyte >= 1); t++) @(negedge iCLK);
        chk("reach_restart_frame", fidx, NF);
        rst_abort = 1; run_model = 0;
        iRESET = 1'b0;
        #1;
        chk("midrst_cs", oCS, 1);
        chk("midrst_clk", oCLK, 1);
        chk("midrst_mosi", oMOSI, 1);
        chk("midrst_tx", oTX, 1);
        repeat (3) @(negedge iCLK);
        iRESET = 1'b1;
        repeat (2 * P + 100) @(negedge iCLK);
        chk("starts_after_reset", starts, NF + 1);
        chk("uart_final", exp_q.size(), 0);
        chk("uart_idle_final", u_on, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
